// File: rtl/csr_access_seq_if.sv
// Bus bundle between the CSR access sequencer and its neighbours: the execute-stage request
// channel, the interrupt sideband, the CSR file port and the response channel to the pipeline.
//   master : the sequencer (accepts requests, drives the CSR file, produces responses)
//   slave  : the environment (pipeline + CSR file)
interface csr_access_seq_if #(
   parameter int unsigned XLEN = 32
);
   // Request channel from execute
   logic            req_valid;
   logic            req_ready;
   logic [2:0]      req_op;
   logic [1:0]      req_sys;
   logic [11:0]     req_csr;
   logic [XLEN-1:0] req_rs1_val;
   logic [4:0]      req_zimm;
   logic [XLEN-1:0] req_pc;
   // Interrupt sideband
   logic            intr_ok;
   logic [XLEN-1:0] intr_pc;
   logic            enintr;
   // CSR file port
   logic [11:0]     csr_addr;
   logic            csr_wren;
   logic [XLEN-1:0] csr_wdata;
   logic [XLEN-1:0] csr_rdata;
   logic            csr_fault;
   logic            csr_ecall;
   logic            csr_mret;
   logic            csr_intr;
   // Response channel to the pipeline
   logic            rsp_valid;
   logic            rsp_ready;
   logic [XLEN-1:0] rsp_rd_data;
   logic            rsp_redirect;
   logic [XLEN-1:0] rsp_pc;
   logic            rsp_illegal;
   logic            rsp_intr;

   modport master (
      input  req_valid, req_op, req_sys, req_csr, req_rs1_val, req_zimm, req_pc,
      input  intr_ok, intr_pc, enintr,
      input  csr_rdata, csr_fault,
      input  rsp_ready,
      output req_ready,
      output csr_addr, csr_wren, csr_wdata, csr_ecall, csr_mret, csr_intr,
      output rsp_valid, rsp_rd_data, rsp_redirect, rsp_pc, rsp_illegal, rsp_intr
   );

   modport slave (
      output req_valid, req_op, req_sys, req_csr, req_rs1_val, req_zimm, req_pc,
      output intr_ok, intr_pc, enintr,
      output csr_rdata, csr_fault,
      output rsp_ready,
      input  req_ready,
      input  csr_addr, csr_wren, csr_wdata, csr_ecall, csr_mret, csr_intr,
      input  rsp_valid, rsp_rd_data, rsp_redirect, rsp_pc, rsp_illegal, rsp_intr
   );
endinterface

// File: rtl/csr_access_seq.sv
// Core-side initiator for the machine-mode CSR file.
// Accepts SYSTEM-class instructions from execute, performs CSR read-modify-write sequences,
// sequences ECALL / MRET / interrupt entry through the CSR file trap strobes, and returns the
// old CSR value or a redirect PC on the response channel.
// Ports:
//   clk   : clock
//   reset : asynchronous, active-high reset
//   bus   : request, interrupt sideband, CSR file port and response channel (master side)
// All outputs except req_ready are registered together with the state.
module csr_access_seq #(
   parameter int unsigned XLEN       = 32,
   parameter bit          INTR_FIRST = 1'b1
) (
   input logic              clk,
   input logic              reset,
   csr_access_seq_if.master bus
);

   typedef enum logic [2:0] {
      StIdle, StRead, StWrite, StEcall, StMret, StIntr, StDone
   } state_e;

   state_e          state_q;
   logic [2:0]      op_q;
   logic [4:0]      zimm_q;
   logic [XLEN-1:0] rs1_q;

   logic [11:0]     csr_addr_q;
   logic            csr_wren_q;
   logic [XLEN-1:0] csr_wdata_q;
   logic            csr_ecall_q;
   logic            csr_mret_q;
   logic            csr_intr_q;

   logic            rsp_valid_q;
   logic [XLEN-1:0] rsp_rd_data_q;
   logic            rsp_redirect_q;
   logic [XLEN-1:0] rsp_pc_q;
   logic            rsp_illegal_q;
   logic            rsp_intr_q;

   logic            take_int;
   logic [XLEN-1:0] src;
   logic [XLEN-1:0] new_val;
   logic            write_needed;

   assign take_int      = bus.enintr & bus.intr_ok;
   assign bus.req_ready = (state_q == StIdle) & ~(take_int & INTR_FIRST);

   // Read-modify-write datapath; op_q[2] selects the immediate forms.
   always_comb begin
      src = op_q[2] ? {{(XLEN-5){1'b0}}, zimm_q} : rs1_q;
      case (op_q[1:0])
         2'b10:   new_val = bus.csr_rdata | src;
         2'b11:   new_val = bus.csr_rdata & ~src;
         default: new_val = src;
      endcase
      // Set/clear with a zero rs1 field is a pure read: no write side effects allowed.
      write_needed = (op_q[1:0] == 2'b01) | (zimm_q != 5'd0);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q        <= StIdle;
         op_q           <= '0;
         zimm_q         <= '0;
         rs1_q          <= '0;
         csr_addr_q     <= '0;
         csr_wren_q     <= 1'b0;
         csr_wdata_q    <= '0;
         csr_ecall_q    <= 1'b0;
         csr_mret_q     <= 1'b0;
         csr_intr_q     <= 1'b0;
         rsp_valid_q    <= 1'b0;
         rsp_rd_data_q  <= '0;
         rsp_redirect_q <= 1'b0;
         rsp_pc_q       <= '0;
         rsp_illegal_q  <= 1'b0;
         rsp_intr_q     <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (take_int && (INTR_FIRST || !bus.req_valid)) begin
                  state_q     <= StIntr;
                  csr_intr_q  <= 1'b1;
                  csr_wren_q  <= 1'b1;
                  csr_wdata_q <= bus.intr_pc;
               end else if (bus.req_valid) begin
                  // req_ready is necessarily high on this branch.
                  op_q   <= bus.req_op;
                  zimm_q <= bus.req_zimm;
                  rs1_q  <= bus.req_rs1_val;
                  case (bus.req_op)
                     3'b001, 3'b010, 3'b011, 3'b101, 3'b110, 3'b111: begin
                        state_q    <= StRead;
                        csr_addr_q <= bus.req_csr;
                     end
                     3'b000: begin
                        if (bus.req_sys == 2'b01) begin
                           state_q     <= StEcall;
                           csr_ecall_q <= 1'b1;
                           csr_wren_q  <= 1'b1;
                           csr_wdata_q <= bus.req_pc;
                        end else if (bus.req_sys == 2'b10) begin
                           state_q    <= StMret;
                           csr_mret_q <= 1'b1;
                        end else begin
                           state_q       <= StDone;
                           rsp_valid_q   <= 1'b1;
                           rsp_illegal_q <= 1'b1;
                        end
                     end
                     default: begin
                        state_q       <= StDone;
                        rsp_valid_q   <= 1'b1;
                        rsp_illegal_q <= 1'b1;
                     end
                  endcase
               end
            end
            StRead: begin
               if (bus.csr_fault) begin
                  state_q       <= StDone;
                  csr_addr_q    <= '0;
                  rsp_valid_q   <= 1'b1;
                  rsp_illegal_q <= 1'b1;
               end else begin
                  rsp_rd_data_q <= bus.csr_rdata;
                  if (write_needed) begin
                     state_q     <= StWrite;
                     csr_wren_q  <= 1'b1;
                     csr_wdata_q <= new_val;
                  end else begin
                     state_q     <= StDone;
                     csr_addr_q  <= '0;
                     rsp_valid_q <= 1'b1;
                  end
               end
            end
            StWrite: begin
               state_q     <= StDone;
               csr_addr_q  <= '0;
               csr_wren_q  <= 1'b0;
               csr_wdata_q <= '0;
               rsp_valid_q <= 1'b1;
            end
            StEcall, StMret, StIntr: begin
               // The CSR file presents the redirect target while the strobe is up.
               state_q        <= StDone;
               csr_ecall_q    <= 1'b0;
               csr_mret_q     <= 1'b0;
               csr_intr_q     <= 1'b0;
               csr_wren_q     <= 1'b0;
               csr_wdata_q    <= '0;
               rsp_valid_q    <= 1'b1;
               rsp_redirect_q <= 1'b1;
               rsp_pc_q       <= bus.csr_rdata;
               rsp_intr_q     <= (state_q == StIntr);
            end
            StDone: begin
               if (bus.rsp_ready) begin
                  state_q        <= StIdle;
                  rsp_valid_q    <= 1'b0;
                  rsp_rd_data_q  <= '0;
                  rsp_redirect_q <= 1'b0;
                  rsp_pc_q       <= '0;
                  rsp_illegal_q  <= 1'b0;
                  rsp_intr_q     <= 1'b0;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign bus.csr_addr     = csr_addr_q;
   assign bus.csr_wren     = csr_wren_q;
   assign bus.csr_wdata    = csr_wdata_q;
   assign bus.csr_ecall    = csr_ecall_q;
   assign bus.csr_mret     = csr_mret_q;
   assign bus.csr_intr     = csr_intr_q;
   assign bus.rsp_valid    = rsp_valid_q;
   assign bus.rsp_rd_data  = rsp_rd_data_q;
   assign bus.rsp_redirect = rsp_redirect_q;
   assign bus.rsp_pc       = rsp_pc_q;
   assign bus.rsp_illegal  = rsp_illegal_q;
   assign bus.rsp_intr     = rsp_intr_q;

endmodule

// File: tb/tb_csr_access_seq.sv
// Directed self-checking bench for csr_access_seq. A tiny CSR file model supplies read data:
// addressed reads return csr_val, 0x7C0 faults, trap entry returns the vector and saves mepc,
// MRET returns the saved mepc.
module tb_csr_access_seq;
   localparam logic [31:0] MTVEC = 32'h8000_0000;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   n_cmp = 0;
   int   n_err = 0;
   int   wren_cnt = 0;
   int   snap;
   logic [31:0] csr_val = 32'h0;
   logic [31:0] mepc = 32'h0;

   csr_access_seq_if #(.XLEN(32)) bus ();

   csr_access_seq #(.XLEN(32), .INTR_FIRST(1'b1)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   always_comb begin
      bus.csr_fault = (bus.csr_addr == 12'h7C0);
      bus.csr_rdata = csr_val;
      if (bus.csr_ecall || bus.csr_intr) bus.csr_rdata = MTVEC;
      else if (bus.csr_mret) bus.csr_rdata = mepc;
   end

   always @(posedge clk) begin
      if (bus.csr_wren) wren_cnt <= wren_cnt + 1;
      if ((bus.csr_ecall || bus.csr_intr) && bus.csr_wren) mepc <= bus.csr_wdata;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present one request for a single cycle; returns one cycle after acceptance (T+1).
   task automatic issue(input logic [2:0] op, input logic [1:0] sys, input logic [11:0] csr,
                        input logic [31:0] rs1, input logic [4:0] zimm, input logic [31:0] pc);
      bus.req_op      = op;
      bus.req_sys     = sys;
      bus.req_csr     = csr;
      bus.req_rs1_val = rs1;
      bus.req_zimm    = zimm;
      bus.req_pc      = pc;
      bus.req_valid   = 1'b1;
      step();
      bus.req_valid   = 1'b0;
   endtask

   task automatic handshake();
      bus.rsp_ready = 1'b1;
      step();
      bus.rsp_ready = 1'b0;
   endtask

   task automatic test_reset();
      bus.req_valid = 0; bus.req_op = 0; bus.req_sys = 0; bus.req_csr = 0;
      bus.req_rs1_val = 0; bus.req_zimm = 0; bus.req_pc = 0;
      bus.intr_ok = 0; bus.intr_pc = 0; bus.enintr = 0; bus.rsp_ready = 0;
      reset = 1'b1;
      step(); step();
      reset = 1'b0;
      step();
      n_cmp++; if (bus.rsp_valid !== 1'b0) begin n_err++; $display("FAIL reset_rsp_valid: got %0h want 0", bus.rsp_valid); end
      n_cmp++; if (bus.csr_wren !== 1'b0) begin n_err++; $display("FAIL reset_csr_wren: got %0h want 0", bus.csr_wren); end
      n_cmp++; if (bus.req_ready !== 1'b1) begin n_err++; $display("FAIL reset_req_ready: got %0h want 1", bus.req_ready); end
      n_cmp++; if (bus.csr_addr !== 12'h0) begin n_err++; $display("FAIL reset_csr_addr: got %0h want 0", bus.csr_addr); end
   endtask

   task automatic test_rw();
      csr_val = 32'h1234_5678;
      issue(3'b001, 2'b00, 12'h340, 32'hDEAD_BEEF, 5'd3, 32'h0);
      n_cmp++; if (bus.csr_addr !== 12'h340) begin n_err++; $display("FAIL rw_read_addr: got %0h want 340", bus.csr_addr); end
      n_cmp++; if (bus.csr_wren !== 1'b0) begin n_err++; $display("FAIL rw_read_wren: got %0h want 0", bus.csr_wren); end
      step();
      n_cmp++; if (bus.csr_wren !== 1'b1) begin n_err++; $display("FAIL rw_write_wren: got %0h want 1", bus.csr_wren); end
      n_cmp++; if (bus.csr_wdata !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL rw_wdata: got %0h want deadbeef", bus.csr_wdata); end
      n_cmp++; if (bus.rsp_valid !== 1'b0) begin n_err++; $display("FAIL rw_t2_valid: got %0h want 0", bus.rsp_valid); end
      step();
      n_cmp++; if (bus.rsp_valid !== 1'b1) begin n_err++; $display("FAIL rw_t3_valid: got %0h want 1", bus.rsp_valid); end
      n_cmp++; if (bus.rsp_rd_data !== 32'h1234_5678) begin n_err++; $display("FAIL rw_rd_data: got %0h want 12345678", bus.rsp_rd_data); end
      n_cmp++; if (bus.csr_wren !== 1'b0) begin n_err++; $display("FAIL rw_done_wren: got %0h want 0", bus.csr_wren); end
      handshake();
      n_cmp++; if (bus.rsp_valid !== 1'b0) begin n_err++; $display("FAIL rw_after_hs_valid: got %0h want 0", bus.rsp_valid); end
   endtask

   task automatic test_rs_nowrite();
      csr_val = 32'hABCD_0001;
      snap = wren_cnt;
      issue(3'b010, 2'b00, 12'h300, 32'h0000_FFFF, 5'd0, 32'h0);
      step();
      n_cmp++; if (bus.rsp_valid !== 1'b1) begin n_err++; $display("FAIL rs0_t2_valid: got %0h want 1", bus.rsp_valid); end
      n_cmp++; if (bus.rsp_rd_data !== 32'hABCD_0001) begin n_err++; $display("FAIL rs0_rd_data: got %0h want abcd0001", bus.rsp_rd_data); end
      n_cmp++; if (wren_cnt !== snap) begin n_err++; $display("FAIL rs0_no_write: got %0d writes want 0", wren_cnt - snap); end
      handshake();
   endtask

   task automatic test_rci();
      csr_val = 32'h0000_0888;
      issue(3'b111, 2'b00, 12'h304, 32'hFFFF_FFFF, 5'h08, 32'h0);
      step();
      n_cmp++; if (bus.csr_wren !== 1'b1) begin n_err++; $display("FAIL rci_wren: got %0h want 1", bus.csr_wren); end
      n_cmp++; if (bus.csr_wdata !== 32'h0000_0880) begin n_err++; $display("FAIL rci_wdata: got %0h want 880", bus.csr_wdata); end
      n_cmp++; if (bus.csr_addr !== 12'h304) begin n_err++; $display("FAIL rci_addr: got %0h want 304", bus.csr_addr); end
      step();
      n_cmp++; if (bus.rsp_rd_data !== 32'h0000_0888) begin n_err++; $display("FAIL rci_rd_data: got %0h want 888", bus.rsp_rd_data); end
      handshake();
   endtask

   task automatic test_fault();
      csr_val = 32'h5A5A_5A5A;
      snap = wren_cnt;
      issue(3'b001, 2'b00, 12'h7C0, 32'h1, 5'd1, 32'h0);
      step();
      n_cmp++; if (bus.rsp_valid !== 1'b1) begin n_err++; $display("FAIL fault_valid: got %0h want 1", bus.rsp_valid); end
      n_cmp++; if (bus.rsp_illegal !== 1'b1) begin n_err++; $display("FAIL fault_illegal: got %0h want 1", bus.rsp_illegal); end
      n_cmp++; if (bus.rsp_rd_data !== 32'h0) begin n_err++; $display("FAIL fault_rd_data: got %0h want 0", bus.rsp_rd_data); end
      n_cmp++; if (wren_cnt !== snap) begin n_err++; $display("FAIL fault_no_write: got %0d writes want 0", wren_cnt - snap); end
      handshake();
      n_cmp++; if (bus.rsp_illegal !== 1'b0) begin n_err++; $display("FAIL fault_clear: got %0h want 0", bus.rsp_illegal); end
   endtask

   task automatic test_illegal();
      issue(3'b100, 2'b00, 12'h340, 32'h1, 5'd1, 32'h0);
      n_cmp++; if (bus.rsp_valid !== 1'b1) begin n_err++; $display("FAIL ill_op_valid: got %0h want 1", bus.rsp_valid); end
      n_cmp++; if (bus.rsp_illegal !== 1'b1) begin n_err++; $display("FAIL ill_op_illegal: got %0h want 1", bus.rsp_illegal); end
      n_cmp++; if ({bus.csr_wren, bus.csr_ecall, bus.csr_mret, bus.csr_intr} !== 4'b0) begin n_err++; $display("FAIL ill_op_strobes: got %b want 0000", {bus.csr_wren, bus.csr_ecall, bus.csr_mret, bus.csr_intr}); end
      n_cmp++; if (bus.csr_addr !== 12'h0) begin n_err++; $display("FAIL ill_op_addr: got %0h want 0", bus.csr_addr); end
      handshake();
      issue(3'b000, 2'b11, 12'h0, 32'h0, 5'd0, 32'h40);
      n_cmp++; if (bus.rsp_illegal !== 1'b1) begin n_err++; $display("FAIL ill_sys_illegal: got %0h want 1", bus.rsp_illegal); end
      n_cmp++; if (bus.rsp_redirect !== 1'b0) begin n_err++; $display("FAIL ill_sys_redirect: got %0h want 0", bus.rsp_redirect); end
      handshake();
   endtask

   task automatic test_ecall();
      issue(3'b000, 2'b01, 12'h0, 32'h0, 5'd0, 32'h0000_0100);
      n_cmp++; if ({bus.csr_ecall, bus.csr_wren} !== 2'b11) begin n_err++; $display("FAIL ecall_strobes: got %b want 11", {bus.csr_ecall, bus.csr_wren}); end
      n_cmp++; if (bus.csr_wdata !== 32'h0000_0100) begin n_err++; $display("FAIL ecall_wdata: got %0h want 100", bus.csr_wdata); end
      step();
      n_cmp++; if (bus.rsp_valid !== 1'b1) begin n_err++; $display("FAIL ecall_valid: got %0h want 1", bus.rsp_valid); end
      n_cmp++; if (bus.rsp_redirect !== 1'b1) begin n_err++; $display("FAIL ecall_redirect: got %0h want 1", bus.rsp_redirect); end
      n_cmp++; if (bus.rsp_pc !== MTVEC) begin n_err++; $display("FAIL ecall_pc: got %0h want 80000000", bus.rsp_pc); end
      n_cmp++; if (bus.rsp_intr !== 1'b0) begin n_err++; $display("FAIL ecall_intr: got %0h want 0", bus.rsp_intr); end
      n_cmp++; if (bus.csr_ecall !== 1'b0) begin n_err++; $display("FAIL ecall_strobe_drop: got %0h want 0", bus.csr_ecall); end
      handshake();
   endtask

   task automatic test_mret();
      issue(3'b000, 2'b10, 12'h0, 32'h0, 5'd0, 32'h0000_0300);
      n_cmp++; if ({bus.csr_mret, bus.csr_wren} !== 2'b10) begin n_err++; $display("FAIL mret_strobes: got %b want 10", {bus.csr_mret, bus.csr_wren}); end
      step();
      n_cmp++; if (bus.rsp_pc !== 32'h0000_0100) begin n_err++; $display("FAIL mret_pc: got %0h want 100", bus.rsp_pc); end
      n_cmp++; if (bus.rsp_redirect !== 1'b1) begin n_err++; $display("FAIL mret_redirect: got %0h want 1", bus.rsp_redirect); end
      handshake();
   endtask

   task automatic test_intr_first();
      csr_val = 32'h0000_5555;
      bus.enintr = 1'b1; bus.intr_ok = 1'b1; bus.intr_pc = 32'h0000_0200;
      bus.req_op = 3'b001; bus.req_sys = 2'b00; bus.req_csr = 12'h340;
      bus.req_rs1_val = 32'h1111_2222; bus.req_zimm = 5'd2; bus.req_pc = 32'h0;
      bus.req_valid = 1'b1;
      #1;
      n_cmp++; if (bus.req_ready !== 1'b0) begin n_err++; $display("FAIL intr_req_ready: got %0h want 0", bus.req_ready); end
      step();
      n_cmp++; if ({bus.csr_intr, bus.csr_wren} !== 2'b11) begin n_err++; $display("FAIL intr_strobes: got %b want 11", {bus.csr_intr, bus.csr_wren}); end
      n_cmp++; if (bus.csr_wdata !== 32'h0000_0200) begin n_err++; $display("FAIL intr_wdata: got %0h want 200", bus.csr_wdata); end
      bus.enintr = 1'b0;
      step();
      n_cmp++; if ({bus.rsp_valid, bus.rsp_intr, bus.rsp_redirect} !== 3'b111) begin n_err++; $display("FAIL intr_rsp_flags: got %b want 111", {bus.rsp_valid, bus.rsp_intr, bus.rsp_redirect}); end
      n_cmp++; if (bus.rsp_pc !== MTVEC) begin n_err++; $display("FAIL intr_pc: got %0h want 80000000", bus.rsp_pc); end
      n_cmp++; if (bus.req_ready !== 1'b0) begin n_err++; $display("FAIL intr_busy_ready: got %0h want 0", bus.req_ready); end
      handshake();
      // Pending request is taken back-to-back in the first idle cycle.
      n_cmp++; if (bus.req_ready !== 1'b1) begin n_err++; $display("FAIL intr_idle_ready: got %0h want 1", bus.req_ready); end
      step();
      bus.req_valid = 1'b0;
      n_cmp++; if (bus.csr_addr !== 12'h340) begin n_err++; $display("FAIL intr_req_addr: got %0h want 340", bus.csr_addr); end
      step();
      n_cmp++; if (bus.csr_wdata !== 32'h1111_2222) begin n_err++; $display("FAIL intr_req_wdata: got %0h want 11112222", bus.csr_wdata); end
      step();
      n_cmp++; if (bus.rsp_rd_data !== 32'h0000_5555) begin n_err++; $display("FAIL intr_req_rd: got %0h want 5555", bus.rsp_rd_data); end
      n_cmp++; if (bus.rsp_intr !== 1'b0) begin n_err++; $display("FAIL intr_req_flag: got %0h want 0", bus.rsp_intr); end
      handshake();
      bus.intr_ok = 1'b0;
   endtask

   task automatic test_stall();
      csr_val = 32'h0000_0100;
      issue(3'b010, 2'b00, 12'h305, 32'h0000_00F0, 5'd5, 32'h0);
      step();
      n_cmp++; if (bus.csr_wdata !== 32'h0000_01F0) begin n_err++; $display("FAIL stall_wdata: got %0h want 1f0", bus.csr_wdata); end
      step();
      csr_val = 32'hFFFF_FFFF;
      for (int i = 0; i < 5; i++) begin
         n_cmp++; if ({bus.rsp_valid, bus.rsp_illegal, bus.rsp_redirect} !== 3'b100) begin n_err++; $display("FAIL stall_flags_%0d: got %b want 100", i, {bus.rsp_valid, bus.rsp_illegal, bus.rsp_redirect}); end
         n_cmp++; if (bus.rsp_rd_data !== 32'h0000_0100) begin n_err++; $display("FAIL stall_rd_%0d: got %0h want 100", i, bus.rsp_rd_data); end
         step();
      end
      handshake();
      n_cmp++; if (bus.rsp_valid !== 1'b0) begin n_err++; $display("FAIL stall_release: got %0h want 0", bus.rsp_valid); end
   endtask

   task automatic test_reset_mid();
      csr_val = 32'h0000_0001;
      issue(3'b001, 2'b00, 12'h340, 32'h0000_0077, 5'd1, 32'h0);
      step();
      n_cmp++; if (bus.csr_wren !== 1'b1) begin n_err++; $display("FAIL rstmid_pre_wren: got %0h want 1", bus.csr_wren); end
      reset = 1'b1;
      #1;
      n_cmp++; if (bus.csr_wren !== 1'b0) begin n_err++; $display("FAIL rstmid_wren: got %0h want 0", bus.csr_wren); end
      n_cmp++; if (bus.rsp_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_valid: got %0h want 0", bus.rsp_valid); end
      n_cmp++; if (bus.req_ready !== 1'b1) begin n_err++; $display("FAIL rstmid_idle: got %0h want 1", bus.req_ready); end
      snap = wren_cnt;
      step();
      reset = 1'b0;
      step(); step();
      n_cmp++; if (wren_cnt !== snap) begin n_err++; $display("FAIL rstmid_no_write: got %0d writes want 0", wren_cnt - snap); end
      n_cmp++; if (bus.rsp_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_post_valid: got %0h want 0", bus.rsp_valid); end
   endtask

   initial begin
      test_reset();
      test_rw();
      test_rs_nowrite();
      test_rci();
      test_fault();
      test_illegal();
      test_ecall();
      test_mret();
      test_intr_first();
      test_stall();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish within 100000 time units");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/csr_access_seq.md
Name: csr_access_seq

Overview:
- Core-side initiator for the machine-mode CSR file. Accepts decoded SYSTEM-class instructions from the execute stage over a valid/ready handshake.
- Handles CSR instructions (CSRRW/RS/RC and their immediate forms) with a read–modify–write sequence on the CSR file port.
- Sequences ECALL, MRET and interrupt entry by driving the CSR file's trap strobes.
- Returns the rd value, or a redirect PC, to the pipeline over a valid/ready response channel.

Parameters:
- XLEN, 32, data width; must be 32.
- INTR_FIRST, 1, 1: a pending interrupt pre-empts a simultaneous request in IDLE; 0: the request wins.

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-high reset
- req_valid  input  1  request present
- req_ready  output  1  request accepted this cycle when high with req_valid
- req_op  input  3  funct3: 001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI, 000 system, 100 illegal
- req_sys  input  2  for op 000: 01 ECALL, 10 MRET, other values illegal
- req_csr  input  12  CSR address
- req_rs1_val  input  32  rs1 register value
- req_zimm  input  5  rs1 field / zero-extended immediate
- req_pc  input  32  PC of the instruction
- intr_ok  input  1  core is at an instruction boundary; interrupt may be taken
- intr_pc  input  32  PC to save on interrupt entry
- enintr  input  1  CSR file: interrupt pending and enabled
- csr_addr  output  12  CSR file address
- csr_wren  output  1  CSR file write strobe
- csr_wdata  output  32  CSR file write data
- csr_rdata  input  32  CSR file combinational read data
- csr_fault  input  1  CSR file access fault
- csr_ecall, csr_mret, csr_intr  output  1 each  CSR file trap strobes
- rsp_valid  output  1  response valid
- rsp_ready  input  1  response accepted
- rsp_rd_data  output  32  old CSR value (for rd)
- rsp_redirect  output  1  rsp_pc is valid; pipeline must redirect fetch
- rsp_pc  output  32  redirect target
- rsp_illegal  output  1  illegal instruction or CSR fault
- rsp_intr  output  1  response was produced by interrupt entry

Behaviour:
- Reset (async): state IDLE. All outputs 0 except req_ready, which follows the IDLE rule below. Reset mid-operation aborts immediately; no further strobes are issued.
- Outputs are registered from state. Strobes are 0 in any state that does not name them. csr_addr holds the latched address in READ and WRITE.

States:
- IDLE
  - take_int = enintr & intr_ok.
  - req_ready = !(take_int & INTR_FIRST).
  - If take_int (and INTR_FIRST=1, or no req_valid) -> INTR.
  - Else on req_valid & req_ready: latch all request fields.
    - Op RW/RS/RC/RWI/RSI/RCI -> READ.
    - Op 000 with sys 01 -> ECALL.
    - Op 000 with sys 10 -> MRET.
    - Anything else -> DONE with rsp_illegal=1; no CSR access.
- READ
  - csr_wren=0; old = csr_rdata.
  - If csr_fault -> DONE with rsp_illegal=1; no write is issued.
  - Else compute new, with src = req_rs1_val (register forms) or {27'b0, zimm} (immediate forms):
    - RW: new = src.
    - RS: new = old | src.
    - RC: new = old & ~src.
  - Write needed: RW/RWI always; RS/RC/RSI/RCI only when zimm != 0.
  - Write needed -> WRITE; else -> DONE. rsp_rd_data = old.
- WRITE
  - csr_wren=1, csr_wdata=new, one cycle -> DONE.
- ECALL
  - csr_ecall=1, csr_wren=1, csr_wdata=req_pc, one cycle.
  - rsp_pc = csr_rdata (trap vector), rsp_redirect=1 -> DONE.
- INTR
  - csr_intr=1, csr_wren=1, csr_wdata=intr_pc, one cycle.
  - rsp_pc = csr_rdata, rsp_redirect=1, rsp_intr=1 -> DONE.
- MRET
  - csr_mret=1, csr_wren=0, one cycle.
  - rsp_pc = csr_rdata (saved epc), rsp_redirect=1 -> DONE.
- DONE
  - rsp_valid=1; all rsp_* fields stable until rsp_ready.
  - On rsp_ready -> IDLE; rsp_valid drops next cycle. Back-to-back acceptance is possible the following cycle.

Latency (accept at cycle T):
- Write: rsp_valid at T+3.
- No-write read, ECALL, MRET, INTR: rsp_valid at T+2.
- Illegal: rsp_valid at T+1.

Other rules:
- enintr is ignored outside IDLE. An interrupt arriving mid-sequence waits until the next IDLE.
- rsp_rd_data is 0 for system, interrupt and illegal responses.

Test Plan:
- CSRRW csr 0x340, rs1_val 0xDEADBEEF, CSR holds 0x12345678 -> csr_wren=1 with wdata 0xDEADBEEF at T+2; rsp_rd_data 0x12345678 at T+3.
- CSRRS 0x300, zimm=0 -> csr_wren never asserted; rsp at T+2 with old value. CSRRCI 0x304, zimm=0x08, old 0x888 -> wdata 0x880.
- CSRRW to unmapped 0x7C0 (csr_fault=1) -> no csr_wren; rsp_illegal=1. Op 100 -> rsp_illegal at T+1 with no csr_* activity.
- ECALL pc 0x100, CSR file returns vector 0x80000000 -> csr_ecall & csr_wren with wdata 0x100; rsp_redirect=1, rsp_pc 0x80000000.
- enintr=1, intr_ok=1 together with req_valid (INTR_FIRST=1) -> req_ready=0, INTR sequence with rsp_intr=1; request accepted only after rsp handshake. MRET then returns rsp_pc = saved 0x100.
- rsp_ready held low 5 cycles -> rsp fields stable. Reset asserted during WRITE -> csr_wren drops asynchronously, state IDLE, rsp_valid=0.
